// File: rtl/flipflop_pkg.sv
// Shared definitions for the flip-flop conversion library: JK command
// encodings and the legal counter width range.
package flipflop_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 16;

endpackage

// File: rtl/jk_ff_arn.sv
// One-bit JK flip-flop with asynchronous active-low reset to 0.
module jk_ff_arn
    import flipflop_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD:   q <= q;
                JK_RESET:  q <= 1'b0;
                JK_SET:    q <= 1'b1;
                JK_TOGGLE: q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_updown_counter.sv
// Up/down counter with parallel load built from per-bit JK cells; this
// module computes the J/K excitation and the terminal-count/wrap flags.
module jk_updown_counter
    import flipflop_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] ones_below;
    logic [WIDTH-1:0] zeros_below;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    // Bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        ones_below     = '0;
        zeros_below    = '0;
        ones_below[0]  = 1'b1;
        zeros_below[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            ones_below[i]  = ones_below[i-1] & q[i-1];
            zeros_below[i] = zeros_below[i-1] & ~q[i-1];
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        if (load) begin
            j = din;
            k = ~din;
        end else if (en) begin
            j = up ? ones_below : zeros_below;
            k = up ? ones_below : zeros_below;
        end
    end

    assign tc = en & ~load & ((up & (&q)) | (~up & ~(|q)));

    for (genvar b = 0; b < WIDTH; b++) begin : g_cell
        jk_ff_arn u_ff (
            .clk (clk),
            .rst (rst),
            .j   (j[b]),
            .k   (k[b]),
            .q   (q[b])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= tc;
        end
    end

endmodule

// File: tb/tb_jk_updown_counter.sv
// Directed and randomized bench for jk_updown_counter (WIDTH=4) against a
// modulo-arithmetic reference model.
module tb_jk_updown_counter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] din;
    logic [W-1:0] q;
    logic         tc;
    logic         wrap;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    int m_q    = 0;
    int m_wrap = 0;

    jk_updown_counter #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .up   (up),
        .load (load),
        .din  (din),
        .q    (q),
        .tc   (tc),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_tc(input int l, input int e, input int u, input int cur);
        return (l == 0 && e == 1 && ((u == 1 && cur == MOD - 1) || (u == 0 && cur == 0))) ? 1 : 0;
    endfunction

    // Apply one command, check tc before the edge and q/wrap after it.
    task automatic step(input string tag, input int l, input int e, input int u, input int d);
        int exp_tc;
        load = l[0];
        en   = e[0];
        up   = u[0];
        din  = d[W-1:0];
        #1;
        exp_tc = model_tc(l, e, u, m_q);
        check({tag, ".tc"}, {31'b0, tc}, exp_tc);
        @(posedge clk);
        if (l != 0)      m_q = d % MOD;
        else if (e != 0) m_q = (u != 0) ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
        m_wrap = exp_tc;
        #1;
        check({tag, ".q"},    {28'b0, q},    m_q);
        check({tag, ".wrap"}, {31'b0, wrap}, m_wrap);
    endtask

    initial begin
        rst  = 1'b0;
        en   = 1'b1;
        up   = 1'b0;
        load = 1'b0;
        din  = '0;

        // Reset held with en=1, up=0: q and wrap stay 0, tc reads 1.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst.q",    {28'b0, q},    0);
            check("rst.wrap", {31'b0, wrap}, 0);
            check("rst.tc",   {31'b0, tc},   1);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step("hold", 0, 0, 0, 0);

        // Up-count through the wrap.
        for (int i = 0; i < 17; i++) step("up", 0, 1, 1, 0);
        step("up_after", 0, 1, 1, 0);

        // Down-count wrap from 0.
        step("dn_load", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("dn", 0, 1, 0, 0);

        // Load priority over counting, and no wrap from load at all-ones.
        step("lp_load5", 1, 0, 0, 5);
        step("lp_load10", 1, 1, 1, 10);
        step("lp_load15", 1, 0, 0, 15);
        step("lp_noinc", 1, 1, 1, 3);

        // Direction changes on consecutive edges.
        step("dir_load7", 1, 0, 0, 7);
        step("dir0", 0, 1, 1, 0);
        step("dir1", 0, 1, 1, 0);
        step("dir2", 0, 1, 0, 0);
        step("dir3", 0, 1, 0, 0);
        step("dir4", 0, 1, 1, 0);

        // Asynchronous reset mid-count at q=9.
        step("ar_load9", 1, 0, 0, 9);
        #3;
        rst = 1'b0;
        #1;
        m_q = 0;
        m_wrap = 0;
        check("ar.q",    {28'b0, q},    0);
        check("ar.wrap", {31'b0, wrap}, 0);
        #1;
        rst = 1'b1;
        step("ar_cnt", 0, 1, 1, 0);

        // Asynchronous reset clears a pending wrap pulse.
        step("aw_load15", 1, 0, 0, 15);
        step("aw_wrap", 0, 1, 1, 0);
        #3;
        rst = 1'b0;
        #1;
        m_q = 0;
        m_wrap = 0;
        check("aw.q",    {28'b0, q},    0);
        check("aw.wrap", {31'b0, wrap}, 0);
        #1;
        rst = 1'b1;

        // Randomized commands; load kept rare so counting dominates.
        for (int i = 0; i < 300; i++) begin
            int l;
            l = ($urandom_range(0, 7) == 0) ? 1 : 0;
            step("rand", l, int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, MOD - 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
